// File: rtl/parity_splitter_pkg.sv
// Shared definitions for parity_splitter: FSM state encoding, bucket-select
// codes and a width helper for bucket read indices.
package parity_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam logic EVEN_SEL = 1'b0;
    localparam logic ODD_SEL  = 1'b1;

    // A single-entry bucket still needs a 1-bit index port.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/parity_bucket.sv
// One bucket: storage, saturating count, full flag, insert and masked read.
// PARITY_SPLITTER_SORT_EN selects ascending sorted insertion over append.
module parity_bucket
    import parity_splitter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 8,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1),
    parameter int IDX_W     = idx_width(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [DATA_W-1:0] mem_d [BUF_DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;

    assign full  = (count_q == CNT_W'(BUF_DEPTH));
    assign count = count_q;

`ifdef PARITY_SPLITTER_SORT_EN
    // gt[i]: valid entry i is strictly greater than the incoming word, so equals stay ahead.
    logic [BUF_DEPTH-1:0] gt, gt_prev;

    always_comb begin
        gt = '0;
        for (int i = 0; i < BUF_DEPTH; i++)
            gt[i] = (CNT_W'(i) < count_q) && (mem_q[i] > wr_data);
        gt_prev = gt << 1;
    end
`endif

    always_comb begin
        count_d = count_q;
        mem_d   = mem_q;
        if (clr) begin
            count_d = '0;
        end else if (wr_en && !full) begin
            count_d = count_q + 1'b1;
            for (int i = 0; i < BUF_DEPTH; i++) begin
`ifdef PARITY_SPLITTER_SORT_EN
                if (gt[i] || CNT_W'(i) == count_q)
                    mem_d[i] = gt_prev[i] ? mem_q[(i > 0) ? i - 1 : 0] : wr_data;
`else
                if (CNT_W'(i) == count_q)
                    mem_d[i] = wr_data;
`endif
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < BUF_DEPTH; i++)
            if (IDX_W'(i) == rd_idx && CNT_W'(i) < count_q)
                rd_data = mem_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/parity_splitter.sv
// Streams N_ITEMS ROM words into odd/even buckets with a start/busy/done handshake.
// Define PARITY_SPLITTER_SORT_EN to keep each bucket in ascending order.
module parity_splitter
    import parity_splitter_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int ADDR_W    = 4,
    parameter  int N_ITEMS   = 8,
    parameter  int BUF_DEPTH = 8,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1),
    localparam int IDX_W     = idx_width(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rd_sel,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  even_count,
    output logic [CNT_W-1:0]  odd_count,
    output logic              overflow
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              vld_q, vld_d, ovf_q, ovf_d;
    logic              accept, wr_even, wr_odd, full_even, full_odd;
    logic [DATA_W-1:0] rd_even, rd_odd;

    assign accept  = (state_q == IDLE) && start;
    // vld_q marks that rom_data belongs to the address issued on the previous edge.
    assign wr_odd  = vld_q && rom_data[0];
    assign wr_even = vld_q && !rom_data[0];

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        vld_d      = (state_q == RUN);
        ovf_d      = ovf_q | (wr_odd && full_odd) | (wr_even && full_even);
        case (state_q)
            IDLE: if (start) begin
                state_d    = RUN;
                rom_addr_d = '0;
                busy_d     = 1'b1;
                ovf_d      = 1'b0;
            end
            RUN: begin
                if (rom_addr_q == ADDR_W'(N_ITEMS - 1)) state_d = DRAIN;
                else rom_addr_d = rom_addr_q + 1'b1;
            end
            DRAIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vld_q      <= vld_d;
            ovf_q      <= ovf_d;
        end
    end

    parity_bucket #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_even (
        .clk(clk), .rst(rst), .clr(accept), .wr_en(wr_even), .wr_data(rom_data),
        .rd_idx(rd_idx), .rd_data(rd_even), .count(even_count), .full(full_even)
    );

    parity_bucket #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_odd (
        .clk(clk), .rst(rst), .clr(accept), .wr_en(wr_odd), .wr_data(rom_data),
        .rd_idx(rd_idx), .rd_data(rd_odd), .count(odd_count), .full(full_odd)
    );

    assign rd_data  = (rd_sel == ODD_SEL) ? rd_odd : rd_even;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = rom_addr_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_parity_splitter.sv
// Randomised self-checking bench: a depth-8 and a depth-4 splitter run side by
// side against a queue-based model of the bucket filing rules.
module tb_parity_splitter;

    logic       clk, rst, start, rd_sel;
    logic [2:0] rd_idx;
    logic [1:0] rd_idx4;
    logic       busy, done, overflow, busy4, done4, overflow4;
    logic [3:0] rom_addr, rom_addr4, even_count, odd_count;
    logic [2:0] even_count4, odd_count4;
    logic [7:0] rom_data, rom_data4, rd_data, rd_data4;

    logic [7:0] rom8 [16];
    logic [7:0] rom4 [16];
    logic [7:0] e8[$], o8[$], e4[$], o4[$];
    bit         ovf8, ovf4;
    int         n_checks, n_pass;

    parity_splitter #(.DATA_W(8), .ADDR_W(4), .N_ITEMS(8), .BUF_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data), .rd_sel(rd_sel), .rd_idx(rd_idx),
        .rd_data(rd_data), .even_count(even_count), .odd_count(odd_count), .overflow(overflow)
    );

    parity_splitter #(.DATA_W(8), .ADDR_W(4), .N_ITEMS(8), .BUF_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .busy(busy4), .done(done4),
        .rom_addr(rom_addr4), .rom_data(rom_data4), .rd_sel(rd_sel), .rd_idx(rd_idx4),
        .rd_data(rd_data4), .even_count(even_count4), .odd_count(odd_count4), .overflow(overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= rom8[rom_addr];
        rom_data4 <= rom4[rom_addr4];
    end

    // Position a new word takes: end of bucket, or before the first larger entry when sorting.
    function automatic int slot(input logic [7:0] q[$], input logic [7:0] w);
`ifdef PARITY_SPLITTER_SORT_EN
        foreach (q[j]) if (q[j] > w) return j;
`endif
        return q.size();
    endfunction

    task automatic build_model();
        logic [7:0] w;
        e8.delete(); o8.delete(); e4.delete(); o4.delete();
        ovf8 = 0; ovf4 = 0;
        for (int k = 0; k < 8; k++) begin
            w = rom8[k];
            if (w[0]) begin if (o8.size() < 8) o8.insert(slot(o8, w), w); else ovf8 = 1; end
            else      begin if (e8.size() < 8) e8.insert(slot(e8, w), w); else ovf8 = 1; end
            w = rom4[k];
            if (w[0]) begin if (o4.size() < 4) o4.insert(slot(o4, w), w); else ovf4 = 1; end
            else      begin if (e4.size() < 4) e4.insert(slot(e4, w), w); else ovf4 = 1; end
        end
    endtask

    task automatic load_fixed();
        logic [7:0] fx [8] = '{8'd5, 8'd4, 8'd2, 8'd1, 8'd10, 8'd0, 8'd12, 8'd3};
        for (int k = 0; k < 16; k++) begin
            rom8[k] = (k < 8) ? fx[k] : 8'd0;
            rom4[k] = 8'(2 * k);
        end
        build_model();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk); #1; edges++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        rd_sel = 1'b0; rd_idx = 3'd0; #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %0b%0b want 00", busy, done); else n_pass++;
        n_checks++; if (rom_addr !== 4'd0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else n_pass++;
        n_checks++; if (even_count !== 4'd0 || odd_count !== 4'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", even_count, odd_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || overflow4 !== 1'b0) $display("FAIL reset_overflow got %0b%0b want 00", overflow, overflow4); else n_pass++;
        n_checks++; if (rd_data !== 8'd0) $display("FAIL reset_rd_data got %0d want 0", rd_data); else n_pass++;
    endtask

    task automatic test_fixed();
        int edges;
        logic [7:0] exp;
        load_fixed();
        pulse_start();
        n_checks++; if (busy !== 1'b1 || rom_addr !== 4'd0) $display("FAIL fixed_accept got busy=%0b addr=%0d want busy=1 addr=0", busy, rom_addr); else n_pass++;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk); #1; edges++;
            if (edges <= 7) begin
                n_checks++; if (rom_addr !== 4'(edges)) $display("FAIL fixed_addr_seq got %0d want %0d", rom_addr, edges); else n_pass++;
            end
            if (done) break;
        end
        n_checks++; if (edges !== 9) $display("FAIL fixed_done_latency got %0d want 9", edges); else n_pass++;
        n_checks++; if (even_count !== 4'd5 || odd_count !== 4'd3 || overflow !== 1'b0)
            $display("FAIL fixed_counts got e=%0d o=%0d ovf=%0b want e=5 o=3 ovf=0", even_count, odd_count, overflow); else n_pass++;
        n_checks++; if (even_count4 !== 3'd4 || odd_count4 !== 3'd0 || overflow4 !== 1'b1)
            $display("FAIL full4_counts got e=%0d o=%0d ovf=%0b want e=4 o=0 ovf=1", even_count4, odd_count4, overflow4); else n_pass++;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                rd_sel = s[0]; rd_idx = 3'(i); rd_idx4 = 2'(i); #1;
                if (s == 1) exp = (i < o8.size()) ? o8[i] : 8'd0;
                else        exp = (i < e8.size()) ? e8[i] : 8'd0;
                n_checks++; if (rd_data !== exp) $display("FAIL fixed_rd sel=%0d idx=%0d got %0d want %0d", s, i, rd_data, exp); else n_pass++;
                if (i < 4) begin
                    exp = (s == 0) ? 8'(2 * i) : 8'd0;
                    n_checks++; if (rd_data4 !== exp) $display("FAIL full4_rd sel=%0d idx=%0d got %0d want %0d", s, i, rd_data4, exp); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random();
        int edges;
        logic [7:0] exp;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 16; k++) begin
                rom8[k] = 8'($urandom_range(0, 15));
                rom4[k] = 8'($urandom_range(0, 255)) & ((it % 2 == 0) ? 8'hFE : 8'hFF);
            end
            build_model();
            pulse_start();
            n_checks++; if (overflow4 !== 1'b0 || even_count4 !== 3'd0 || odd_count4 !== 3'd0)
                $display("FAIL rand_accept_clear got ovf=%0b e=%0d o=%0d want 0 0 0", overflow4, even_count4, odd_count4); else n_pass++;
            wait_done(edges);
            n_checks++; if (edges !== 9) $display("FAIL rand_done_latency got %0d want 9", edges); else n_pass++;
            n_checks++; if (even_count !== 4'(e8.size()) || odd_count !== 4'(o8.size()) || overflow !== ovf8)
                $display("FAIL rand_counts8 got e=%0d o=%0d ovf=%0b want e=%0d o=%0d ovf=%0b", even_count, odd_count, overflow, e8.size(), o8.size(), ovf8); else n_pass++;
            n_checks++; if (even_count4 !== 3'(e4.size()) || odd_count4 !== 3'(o4.size()) || overflow4 !== ovf4)
                $display("FAIL rand_counts4 got e=%0d o=%0d ovf=%0b want e=%0d o=%0d ovf=%0b", even_count4, odd_count4, overflow4, e4.size(), o4.size(), ovf4); else n_pass++;
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < 8; i++) begin
                    rd_sel = s[0]; rd_idx = 3'(i); rd_idx4 = 2'(i); #1;
                    if (s == 1) exp = (i < o8.size()) ? o8[i] : 8'd0;
                    else        exp = (i < e8.size()) ? e8[i] : 8'd0;
                    n_checks++; if (rd_data !== exp) $display("FAIL rand_rd8 sel=%0d idx=%0d got %0d want %0d", s, i, rd_data, exp); else n_pass++;
                    if (i < 4) begin
                        if (s == 1) exp = (i < o4.size()) ? o4[i] : 8'd0;
                        else        exp = (i < e4.size()) ? e4[i] : 8'd0;
                        n_checks++; if (rd_data4 !== exp) $display("FAIL rand_rd4 sel=%0d idx=%0d got %0d want %0d", s, i, rd_data4, exp); else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int edges, n_done;
        load_fixed();
        pulse_start();
        n_done = 0;
        for (edges = 1; edges <= 14; edges++) begin
            if (edges == 3 || edges == 5) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            if (done) n_done++;
            if (edges <= 9) begin
                n_checks++; if (rom_addr !== 4'((edges < 7) ? edges : 7)) $display("FAIL ignore_addr_seq edge=%0d got %0d want %0d", edges, rom_addr, (edges < 7) ? edges : 7); else n_pass++;
            end
        end
        n_checks++; if (n_done !== 1) $display("FAIL ignore_single_done got %0d want 1", n_done); else n_pass++;
        n_checks++; if (even_count !== 4'd5 || odd_count !== 4'd3) $display("FAIL ignore_counts got e=%0d o=%0d want e=5 o=3", even_count, odd_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int edges, n_done;
        logic [7:0] exp;
        load_fixed();
        pulse_start();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || even_count !== 4'd0 || odd_count !== 4'd0 || rom_addr !== 4'd0)
            $display("FAIL midrst_state got busy=%0b e=%0d o=%0d addr=%0d want 0 0 0 0", busy, even_count, odd_count, rom_addr); else n_pass++;
        @(negedge clk); rst = 1'b0;
        n_done = 0;
        repeat (12) begin @(posedge clk); #1; if (done) n_done++; end
        n_checks++; if (n_done !== 0) $display("FAIL midrst_no_done got %0d want 0", n_done); else n_pass++;
        pulse_start();
        wait_done(edges);
        n_checks++; if (edges !== 9) $display("FAIL midrst_rerun_latency got %0d want 9", edges); else n_pass++;
        n_checks++; if (even_count !== 4'd5 || odd_count !== 4'd3 || overflow !== 1'b0)
            $display("FAIL midrst_rerun_counts got e=%0d o=%0d ovf=%0b want 5 3 0", even_count, odd_count, overflow); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            rd_sel = 1'b1; rd_idx = 3'(i); #1;
            exp = o8[i];
            n_checks++; if (rd_data !== exp) $display("FAIL midrst_rd_odd idx=%0d got %0d want %0d", i, rd_data, exp); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        for (int k = 0; k < 16; k++) begin
            rom8[k] = 8'($urandom_range(0, 255));
            rom4[k] = 8'($urandom_range(0, 255));
        end
        build_model();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) begin
            wait_done(edges);
            n_checks++; if (edges !== 9) $display("FAIL b2b_done_latency run=%0d got %0d want 9", r, edges); else n_pass++;
            if (r == 2) begin
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
                n_checks++; if (busy !== 1'b1 || done !== 1'b0 || rom_addr !== 4'd0 || even_count !== 4'd0 || odd_count !== 4'd0 || overflow4 !== 1'b0)
                    $display("FAIL b2b_accept run=%0d got busy=%0b done=%0b addr=%0d e=%0d o=%0d ovf4=%0b want 1 0 0 0 0 0",
                             r, busy, done, rom_addr, even_count, odd_count, overflow4); else n_pass++;
            end
        end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || even_count !== 4'(e8.size()) || odd_count !== 4'(o8.size()))
            $display("FAIL b2b_final got busy=%0b e=%0d o=%0d want 0 %0d %0d", busy, even_count, odd_count, e8.size(), o8.size()); else n_pass++;
        n_checks++; if (overflow4 !== ovf4 || even_count4 !== 3'(e4.size()))
            $display("FAIL b2b_final4 got ovf=%0b e=%0d want %0b %0d", overflow4, even_count4, ovf4, e4.size()); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; rd_sel = 1'b0; rd_idx = '0; rd_idx4 = '0;
        for (int k = 0; k < 16; k++) begin rom8[k] = 8'd0; rom4[k] = 8'd0; end
        test_reset();
        test_fixed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/parity_splitter.md
# parity_splitter

Parametrised odd/even splitter that streams N_ITEMS words out of a synchronous ROM and files each word into an odd or even bucket by its LSB. It is the successor to the fixed 8-entry, 8-bit splitter and sits between the constant ROM and downstream consumers. It adds:
- a start/busy/done handshake
- saturating per-bucket counts and an overflow flag
- a random-access read port
- optional in-bucket ascending sort

## Interface
- DATA_W, 8, word width
- ADDR_W, 4, ROM address width
- N_ITEMS, 8, words processed per run (1..2**ADDR_W)
- BUF_DEPTH, 8, entries per bucket (>=1)
- CNT_W, $clog2(BUF_DEPTH+1), count width (localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- busy  out  1  high from the accepting edge until done
- done  out  1  one-cycle pulse when the last word is filed
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM output, valid one cycle after rom_addr
- rd_sel  in  1  0 = even bucket, 1 = odd bucket
- rd_idx  in  $clog2(BUF_DEPTH)  read index
- rd_data  out  DATA_W  combinational bucket[rd_sel][rd_idx]; 0 if rd_idx >= that bucket's count
- even_count, odd_count  out  CNT_W  words held, saturating at BUF_DEPTH
- overflow  out  1  sticky; set when a word is dropped because its bucket is full

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE
  - start=1 → RUN.
  - On the same edge: rom_addr<=0, both counts<=0, overflow<=0, busy<=1.
  - Bucket contents are not cleared.
- RUN
  - rom_addr increments each edge until it reaches N_ITEMS-1, then → DRAIN.
  - A one-bit valid pipe tracks the address issued on the previous edge.
  - When valid, rom_data is filed on the edge: rom_data[0]=1 → odd bucket, else even.
  - Count +1 if the bucket is not full; otherwise the word is dropped and overflow<=1.
- DRAIN
  - Files the final in-flight word.
  - Then → IDLE with done<=1 for one cycle and busy<=0.
- start while busy is ignored, with no side effects.
- start asserted in the done cycle is accepted, because the FSM is already in IDLE.
- N_ITEMS=1: RUN lasts one edge, then DRAIN.
- rst at any time forces IDLE immediately. Reset values:
  - rom_addr=0, counts=0, overflow=0, busy=0, done=0
  - valid pipe cleared
  - bucket contents unspecified and masked by count=0, so rd_data=0

## Timing
- Edge E0 samples start.
- rom_addr=k after E_k, for k=0..N_ITEMS-1.
- Word k is filed at E_(k+2).
- done is high in the cycle after E_(N_ITEMS+1); run latency is N_ITEMS+1 edges after E0.
- rd_data has zero latency (combinational) and is stable only while busy=0.
- Counts and overflow update on the filing edge.

## Configuration
- Macro: PARITY_SPLITTER_SORT_EN.
- Defined:
  - Each bucket is kept in ascending unsigned order by single-cycle insertion.
  - All entries greater than the new word shift up by one; the new word goes into the gap.
  - Equal values are stable: the new word is placed after existing equals.
  - A word arriving at a full bucket is dropped; it never displaces an existing entry.
- Undefined: words are stored in arrival order at index = count.
- Latency and handshake are identical in both builds.

## Structure
- Package parity_splitter_pkg holds:
  - the state enum (IDLE, RUN, DRAIN)
  - the bucket-select localparams EVEN_SEL=0 and ODD_SEL=1
- Sub-module parity_bucket, instantiated twice. It contains:
  - storage
  - the saturating count
  - the full flag
  - the insert logic (append or sorted, per macro)
  - the masked read

## Test plan
- ROM 5,4,2,1,10,0,12,3; N_ITEMS=8; BUF_DEPTH=8; start pulse:
  - unsorted build: odd=5,1,3 (count 3); even=4,2,10,0,12 (count 5); overflow=0
  - done exactly 9 edges after the start edge
- Same stimulus, PARITY_SPLITTER_SORT_EN defined: odd=1,3,5; even=0,2,4,10,12; rd_idx=5 on even → rd_data=0.
- BUF_DEPTH=4, ROM all even (0,2,…,14): even_count=4 holding 0,2,4,6; odd_count=0; overflow=1. A second start clears overflow to 0 at its accepting edge.
- start re-pulsed at cycles 3 and 5 of a run: ignored; rom_addr sequence unbroken; single done.
- rst asserted at cycle 4 of a run, before the next clk edge:
  - immediately busy=0, counts=0, rom_addr=0
  - no done pulse
  - a fresh start then produces the full first-scenario result
- start held high continuously: back-to-back runs; the new run is accepted in each done cycle; counts reset to 0 at each acceptance.
